uart_cmd_deframer: RTL and testbench
====================================

Name: uart_cmd_deframer

Overview:
- Sits directly downstream of the UART receiver. Consumes its received bytes and parses simple command frames into 128-bit key words and 64-bit plaintext/ciphertext blocks for the Simon 64/128 core.
- Drives the receiver's byte acknowledge.
- Presents each assembled word on a valid/ready interface and flags malformed frames.

Parameters:
- CMD_KEY, 8'h4B, command byte opening a key frame ('K'); 16 payload bytes follow.
- CMD_BLK, 8'h44, command byte opening a data-block frame ('D'); 8 payload bytes follow.
- TIMEOUT_CYC, 32'd1_000_000, inter-byte timeout in clk cycles; used only when TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_reset  input  1  synchronous, active-low reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_avail  input  1  byte available on rx_data.
- rx_error  input  1  receiver framing error (bad stop bit).
- rx_ack  output  1  combinational acknowledge to the receiver; clears its rx_avail and rx_error on the next edge.
- key_out  output  128  assembled key word.
- blk_out  output  64  assembled data block.
- key_valid  output  1  key_out holds a complete key; held until accepted.
- blk_valid  output  1  blk_out holds a complete block; held until accepted.
- word_ready  input  1  consumer accepts whichever valid is high.
- frame_err  output  1  one-cycle pulse on a malformed or aborted frame.

Behaviour:
- Reset (n_reset low at a rising edge): state=IDLE, byte counter=0, key_out=0, blk_out=0, key_valid=0, blk_valid=0, frame_err=0.
  - Applies mid-frame and mid-HOLD: the partial or pending word is discarded.
- rx_ack = n_reset & (rx_error | (rx_avail & state!=HOLD)).
  - Purely combinational, so every byte is consumed exactly once: the byte is captured on the same edge at which the receiver clears rx_avail.
- States: IDLE, COLLECT_KEY, COLLECT_BLK, HOLD.
- IDLE, on rx_avail:
  - rx_data==CMD_KEY -> COLLECT_KEY, counter=0.
  - rx_data==CMD_BLK -> COLLECT_BLK, counter=0.
  - Any other byte -> stay in IDLE, pulse frame_err.
- COLLECT_KEY and COLLECT_BLK, on rx_avail:
  - Shift the byte in big-endian: the first payload byte ends at bits [127:120] of key_out or [63:56] of blk_out. Implemented as shift-left-by-8 with the new byte in bits [7:0].
  - Counter increments (4-bit, 0..15).
  - On the 16th key byte or 8th block byte -> HOLD, with key_valid or blk_valid set on the same edge.
  - The output register is shadowed: key_out and blk_out update only on frame completion. The previous word stays stable during collection.
- HOLD:
  - rx_ack stays low for data bytes, so the receiver keeps the next byte; backpressure is accepted.
  - On word_ready: clear the valid, go to IDLE.
  - Data stays stable while valid is high.
  - Latency: the last payload byte's rx_avail cycle -> valid high on the next cycle.
- rx_error, in any state:
  - Acknowledged (rx_ack high), frame_err pulses, and any in-progress frame is discarded -> IDLE.
  - In HOLD, the pending valid word is retained and stays in HOLD.
  - If rx_error and rx_avail are both high, rx_error wins and the byte is dropped.
- key_valid and blk_valid are never high together.
- word_ready while no valid is high has no effect.
- Command bytes arriving mid-frame are treated as payload; there is no resynchronisation except via error or timeout.

Optional Feature:
- Macro: UART_DEFRAMER_TIMEOUT_EN.
- Defined:
  - A 32-bit cycle counter resets on every consumed byte.
  - It counts while the state is COLLECT_KEY or COLLECT_BLK.
  - When it reaches TIMEOUT_CYC-1: pulse frame_err, discard the partial frame -> IDLE.
  - The counter is not active in IDLE or HOLD.
- Undefined: no counter is synthesised, and a partial frame waits indefinitely.

Test Plan:
- Key frame: send 0x4B followed by bytes 0x00..0x0F, word_ready=1 -> key_valid pulses 1 cycle with key_out=128'h000102030405060708090A0B0C0D0E0F; rx_ack high exactly 17 cycles.
- Block frame with backpressure: send 0x44 followed by 0x11..0x88, word_ready=0 for 50 cycles -> blk_out=64'h1122334455667788 and blk_valid held. A further byte 0x4B is not acked until word_ready=1, then it opens a key frame.
- Bad command: byte 0x5A in IDLE -> frame_err one-cycle pulse, rx_ack for that byte, state stays IDLE, no valid.
- rx_error mid-frame: 0x44 followed by 3 bytes, then rx_error=1 -> rx_ack, frame_err pulse, IDLE. A following full 0x44 frame yields only the new 8 bytes.
- Reset mid-frame: 0x4B followed by 5 bytes, then n_reset low for 1 cycle -> all outputs 0. The next 0x4B frame assembles correctly.
- With UART_DEFRAMER_TIMEOUT_EN and TIMEOUT_CYC=100: 0x44 followed by 2 bytes, then idle -> frame_err exactly 100 cycles after the last ack, return to IDLE.

Source files
------------

// File: rtl/uart_cmd_deframer.sv
// UART command deframer: parses 'K' (16-byte key) and 'D' (8-byte block) frames
// into big-endian words on valid/ready. Optional inter-byte timeout: UART_DEFRAMER_TIMEOUT_EN.
module uart_cmd_deframer #(
  parameter logic [7:0]  CMD_KEY     = 8'h4B,
  parameter logic [7:0]  CMD_BLK     = 8'h44,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_avail,
  input  logic         rx_error,
  output logic         rx_ack,
  output logic [127:0] key_out,
  output logic [63:0]  blk_out,
  output logic         key_valid,
  output logic         blk_valid,
  input  logic         word_ready,
  output logic         frame_err
);

  typedef enum logic [1:0] {IDLE, COLLECT_KEY, COLLECT_BLK, HOLD} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [119:0]   sh_q, sh_d;
  logic [127:0]   key_q, key_d;
  logic [63:0]    blk_q, blk_d;
  logic           kv_q, kv_d, bv_q, bv_d, ferr_q, ferr_d;
  logic           byte_take;

`ifdef UART_DEFRAMER_TIMEOUT_EN
  logic [31:0]    tmo_q, tmo_d;
`endif

  // Acknowledge is combinational so the byte is captured on the edge that clears rx_avail.
  assign rx_ack    = n_reset & (rx_error | (rx_avail & (state_q != HOLD)));
  assign byte_take = rx_avail & ~rx_error & (state_q != HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    key_d   = key_q;
    blk_d   = blk_q;
    kv_d    = kv_q;
    bv_d    = bv_q;
    ferr_d  = 1'b0;

    // An errored byte aborts any partial frame but never a word waiting in HOLD.
    if (rx_error) begin
      ferr_d = 1'b1;
      if (state_q != HOLD) state_d = IDLE;
    end

    unique case (state_q)
      IDLE: begin
        if (byte_take) begin
          cnt_d = 4'd0;
          if (rx_data == CMD_KEY)      state_d = COLLECT_KEY;
          else if (rx_data == CMD_BLK) state_d = COLLECT_BLK;
          else                         ferr_d  = 1'b1;
        end
      end
      COLLECT_KEY: begin
        if (byte_take) begin
          sh_d  = {sh_q[111:0], rx_data};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            key_d   = {sh_q, rx_data};
            kv_d    = 1'b1;
            state_d = HOLD;
          end
        end
      end
      COLLECT_BLK: begin
        if (byte_take) begin
          sh_d  = {sh_q[111:0], rx_data};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            blk_d   = {sh_q[55:0], rx_data};
            bv_d    = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          kv_d    = 1'b0;
          bv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_DEFRAMER_TIMEOUT_EN
    // Counts idle cycles inside a frame; any consumed byte restarts it.
    tmo_d = 32'd0;
    if (!rx_ack && (state_q == COLLECT_KEY || state_q == COLLECT_BLK)) begin
      tmo_d = tmo_q + 32'd1;
      if (tmo_d == TIMEOUT_CYC - 32'd1) begin
        ferr_d  = 1'b1;
        state_d = IDLE;
        tmo_d   = 32'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      kv_q    <= 1'b0;
      bv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      kv_q    <= kv_d;
      bv_q    <= bv_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_DEFRAMER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!n_reset) tmo_q <= 32'd0;
    else          tmo_q <= tmo_d;
  end
`endif

  assign key_out   = key_q;
  assign blk_out   = blk_q;
  assign key_valid = kv_q;
  assign blk_valid = bv_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed bench for uart_cmd_deframer: scoreboard of expected words popped on
// each valid/ready handshake, plus counters of ack/valid/error cycles.
module tb_uart_cmd_deframer;
  logic         clk = 1'b0, n_reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_avail = 1'b0, rx_error = 1'b0, word_ready = 1'b0;
  logic         rx_ack, key_valid, blk_valid, frame_err;
  logic [127:0] key_out;
  logic [63:0]  blk_out;

  uart_cmd_deframer #(.CMD_KEY(8'h4B), .CMD_BLK(8'h44), .TIMEOUT_CYC(32'd100)) dut (
    .clk(clk), .n_reset(n_reset), .rx_data(rx_data), .rx_avail(rx_avail),
    .rx_error(rx_error), .rx_ack(rx_ack), .key_out(key_out), .blk_out(blk_out),
    .key_valid(key_valid), .blk_valid(blk_valid), .word_ready(word_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_key; logic [127:0] data; } exp_t;
  exp_t sbq[$];
  int total = 0, passed = 0;
  int ack_cnt = 0, kv_cnt = 0, bv_cnt = 0, ferr_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Receiver model: hold the byte until acked, then drop rx_avail after that edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_avail = 1'b1;
    @(negedge clk);
    while (!rx_ack && n < 200) begin @(negedge clk); n++; end
    check("ack_wait", rx_ack, 1);
    @(posedge clk);
    #1 rx_avail = 1'b0;
  endtask

  task automatic send_key(input logic [127:0] w);
    send_byte(8'h4B);
    for (int i = 15; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_blk(input logic [63:0] w);
    send_byte(8'h44);
    for (int i = 7; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_key(input logic [127:0] w);
    exp_t e; e.is_key = 1'b1; e.data = w; sbq.push_back(e);
  endtask

  task automatic push_blk(input logic [63:0] w);
    exp_t e; e.is_key = 1'b0; e.data = {64'b0, w}; sbq.push_back(e);
  endtask

  task automatic clr_cnt();
    ack_cnt = 0; kv_cnt = 0; bv_cnt = 0; ferr_cnt = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rx_ack)    ack_cnt++;
    if (key_valid) kv_cnt++;
    if (blk_valid) bv_cnt++;
    if (frame_err) ferr_cnt++;
    if (key_valid | blk_valid) check("valid_excl", key_valid & blk_valid, 0);
    if ((key_valid | blk_valid) && word_ready) begin
      check("sb_nonempty", 128'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_kind", key_valid, e.is_key);
        check("sb_data", key_valid ? key_out : {64'b0, blk_out}, e.data);
      end
    end
  end

  logic [127:0] w;
  logic [63:0]  b;
  int           a, n;

  initial begin
    // Reset: a pending byte must not be acked while n_reset is low
    rx_avail = 1'b1; rx_data = 8'h4B;
    cyc(3);
    check("rst_ack", rx_ack, 0);
    check("rst_key", key_out, 0);
    check("rst_blk", blk_out, 0);
    check("rst_kv", key_valid, 0);
    check("rst_bv", blk_valid, 0);
    check("rst_ferr", frame_err, 0);
    rx_avail = 1'b0; n_reset = 1'b1;
    cyc(1);

    // Key frame, consumer always ready
    word_ready = 1'b1; clr_cnt();
    w = 128'h000102030405060708090A0B0C0D0E0F;
    push_key(w);
    send_key(w);
    cyc(3);
    check("key_ack_cnt", ack_cnt, 17);
    check("key_kv_cnt", kv_cnt, 1);
    check("key_out", key_out, w);
    check("key_bv_cnt", bv_cnt, 0);

    // Block frame with backpressure; next byte must wait in the receiver
    word_ready = 1'b0;
    b = 64'h1122334455667788;
    push_blk(b);
    send_blk(b);
    cyc(50);
    check("bp_bv", blk_valid, 1);
    check("bp_blk", blk_out, b);
    a = ack_cnt;
    rx_data = 8'h4B; rx_avail = 1'b1;
    cyc(5);
    check("bp_noack", ack_cnt, a);
    check("bp_bv_held", blk_valid, 1);
    word_ready = 1'b1;
    send_byte(8'h4B);
    check("bp_bv_clr", blk_valid, 0);
    w = {$urandom, $urandom, $urandom, $urandom};
    push_key(w);
    for (int i = 15; i >= 0; i--) send_byte(w[i*8 +: 8]);
    cyc(3);
    check("bp_key", key_out, w);

    // Bad command byte
    clr_cnt();
    send_byte(8'h5A);
    cyc(3);
    check("bad_ferr", ferr_cnt, 1);
    check("bad_kv", kv_cnt, 0);
    check("bad_bv", bv_cnt, 0);
    b = 64'hCAFEF00D12345678;
    push_blk(b);
    send_blk(b);
    cyc(3);
    check("bad_then_blk", blk_out, b);

    // rx_error mid-frame, with a simultaneous byte that must be dropped
    clr_cnt();
    send_byte(8'h44);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rx_error = 1'b1; rx_avail = 1'b1; rx_data = 8'h99;
    #1 check("err_ack", rx_ack, 1);
    @(posedge clk);
    #1 rx_error = 1'b0; rx_avail = 1'b0;
    cyc(2);
    check("err_ferr", ferr_cnt, 1);
    check("err_bv", bv_cnt, 0);
    b = 64'h0102030405060708;
    push_blk(b);
    send_blk(b);
    cyc(3);
    check("err_then_blk", blk_out, b);

    // Reset mid-frame
    send_byte(8'h4B);
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    n_reset = 1'b0;
    cyc(1);
    n_reset = 1'b1;
    check("mrst_key", key_out, 0);
    check("mrst_blk", blk_out, 0);
    check("mrst_kv", key_valid, 0);
    check("mrst_bv", blk_valid, 0);
    check("mrst_ferr", frame_err, 0);
    w = {$urandom, $urandom, $urandom, $urandom};
    push_key(w);
    send_key(w);
    cyc(3);
    check("mrst_then_key", key_out, w);

    // rx_error while a word waits in HOLD keeps the word
    word_ready = 1'b0;
    b = {$urandom, $urandom};
    push_blk(b);
    send_blk(b);
    cyc(2);
    clr_cnt();
    rx_error = 1'b1;
    #1 check("hold_err_ack", rx_ack, 1);
    cyc(1);
    rx_error = 1'b0;
    cyc(3);
    check("hold_err_ferr", ferr_cnt, 1);
    check("hold_err_bv", blk_valid, 1);
    check("hold_err_blk", blk_out, b);
    word_ready = 1'b1;
    cyc(2);
    check("hold_err_clr", blk_valid, 0);

`ifdef UART_DEFRAMER_TIMEOUT_EN
    // Inter-byte timeout: frame_err 100 cycles after the last acked byte
    clr_cnt();
    send_byte(8'h44); send_byte(8'h11); send_byte(8'h22);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_err && n < 300);
    check("tmo_latency", n, 100);
    cyc(3);
    check("tmo_ferr", ferr_cnt, 1);
    b = 64'hA5A5_5A5A_0F0F_F0F0;
    push_blk(b);
    send_blk(b);
    cyc(3);
    check("tmo_then_blk", blk_out, b);
`endif

    cyc(2);
    check("sb_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
